// File: rtl/dose_scheduler_if.sv
// Dose scheduler bundle: time-of-day inputs, slot configuration,
// patient acknowledge and dispenser status outputs.
interface dose_scheduler_if #(
  parameter int NUM_SLOTS = 4,
  parameter int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
);
  logic [4:0]           hours;
  logic [5:0]           minutes;
  logic                 minute_tick;
  logic                 cfg_we;
  logic [SW-1:0]        cfg_slot;
  logic                 cfg_en;
  logic [4:0]           cfg_hour;
  logic [5:0]           cfg_min;
  logic                 ack;
  logic                 alarm;
  logic                 motor_on;
  logic [SW-1:0]        active_slot;
  logic [NUM_SLOTS-1:0] pending;
  logic [3:0]           missed_count;
  logic                 dose_done;

  modport master (
    output hours, minutes, minute_tick,
    output cfg_we, cfg_slot, cfg_en,
    output cfg_hour, cfg_min, ack,
    input  alarm, motor_on, active_slot,
    input  pending, missed_count, dose_done
  );

  modport slave (
    input  hours, minutes, minute_tick,
    input  cfg_we, cfg_slot, cfg_en,
    input  cfg_hour, cfg_min, ack,
    output alarm, motor_on, active_slot,
    output pending, missed_count, dose_done
  );
endinterface

// File: rtl/dose_scheduler.sv
// Dose-time controller: matches programmed slots against the clock,
// raises an alert, waits for ack and runs the dispense motor.
module dose_scheduler #(
  parameter int NUM_SLOTS       = 4,
  parameter int DISPENSE_CYCLES = 100000000,
  parameter int TIMEOUT_MIN     = 30
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  dose_scheduler_if.slave  dsif
);
  localparam int SW =
    (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int CW =
    (DISPENSE_CYCLES > 1) ? $clog2(DISPENSE_CYCLES) : 1;
  localparam logic [CW-1:0] DLAST =
    CW'(DISPENSE_CYCLES - 1);
  localparam logic [5:0] TLAST = 6'(TIMEOUT_MIN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ALERT,
    S_DISP
  } state_t;

  state_t               r_state;
  logic [NUM_SLOTS-1:0] r_en;
  logic [4:0]           r_hour [NUM_SLOTS];
  logic [5:0]           r_min  [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] r_pending;
  logic [5:0]           r_alert_cnt;
  logic [CW-1:0]        r_disp_cnt;
  logic                 r_alarm;
  logic                 r_motor;
  logic [SW-1:0]        r_active;
  logic [3:0]           r_missed;
  logic                 r_done;

  logic [NUM_SLOTS-1:0] w_match;
  logic [NUM_SLOTS-1:0] w_dis;
  logic [NUM_SLOTS-1:0] w_clr;
  logic [SW-1:0]        w_sel;
  logic                 w_any;

  // Out-of-range stored times are rejected explicitly so they never fire.
  always_comb begin
    w_match = '0;
    w_dis   = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      w_match[i] = dsif.minute_tick
                 && r_en[i]
                 && (r_hour[i] <= 5'd23)
                 && (r_min[i] <= 6'd59)
                 && (r_hour[i] == dsif.hours)
                 && (r_min[i] == dsif.minutes);
      w_dis[i] = dsif.cfg_we && !dsif.cfg_en
               && (dsif.cfg_slot == SW'(i));
    end
  end

  // Lowest set index wins; only registered pending bits are considered.
  always_comb begin
    w_sel = '0;
    w_any = |r_pending;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (r_pending[i]) w_sel = SW'(i);
    end
    w_clr = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      w_clr[i] = (r_state == S_IDLE) && w_any
               && (w_sel == SW'(i));
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_en        <= '0;
      r_pending   <= '0;
      r_alert_cnt <= '0;
      r_disp_cnt  <= '0;
      r_alarm     <= 1'b0;
      r_motor     <= 1'b0;
      r_active    <= '0;
      r_missed    <= '0;
      r_done      <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        r_hour[i] <= '0;
        r_min[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (dsif.cfg_we && dsif.cfg_slot == SW'(i)) begin
          r_en[i]   <= dsif.cfg_en;
          r_hour[i] <= dsif.cfg_hour;
          r_min[i]  <= dsif.cfg_min;
        end
      end

      r_pending <= ((r_pending & ~w_clr) | w_match)
                 & ~w_dis;
      r_done    <= 1'b0;

      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state     <= S_ALERT;
            r_active    <= w_sel;
            r_alert_cnt <= '0;
            r_alarm     <= 1'b1;
          end
        end
        S_ALERT: begin
          if (dsif.ack) begin
            r_state    <= S_DISP;
            r_disp_cnt <= '0;
            r_alarm    <= 1'b0;
            r_motor    <= 1'b1;
          end else if (dsif.minute_tick) begin
            if (r_alert_cnt == TLAST) begin
              r_state <= S_IDLE;
              r_alarm <= 1'b0;
              if (r_missed != 4'd15)
                r_missed <= r_missed + 4'd1;
            end else begin
              r_alert_cnt <= r_alert_cnt + 6'd1;
            end
          end
        end
        S_DISP: begin
          if (r_disp_cnt == DLAST) begin
            r_state <= S_IDLE;
            r_motor <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_disp_cnt <= r_disp_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_alarm <= 1'b0;
          r_motor <= 1'b0;
        end
      endcase
    end
  end

  assign dsif.alarm        = r_alarm;
  assign dsif.motor_on     = r_motor;
  assign dsif.active_slot  = r_active;
  assign dsif.pending      = r_pending;
  assign dsif.missed_count = r_missed;
  assign dsif.dose_done    = r_done;
endmodule

// File: tb/tb_dose_scheduler.sv
// Directed bench for dose_scheduler: table of per-cycle vectors
// plus hand sequences for timeout/ack race, saturation and reset.
module tb_dose_scheduler;
  localparam int NS = 4;
  localparam int DC = 10;
  localparam int TO = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  dose_scheduler_if #(.NUM_SLOTS(NS)) bus();

  dose_scheduler #(
    .NUM_SLOTS(NS),
    .DISPENSE_CYCLES(DC),
    .TIMEOUT_MIN(TO)
  ) dut (
    .CLOCK_50(clk),
    .reset(rst),
    .dsif(bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef enum logic [1:0] {NOP, TCK, CFG, ACK} op_t;

  typedef struct packed {
    op_t        op;
    logic [1:0] sl;
    logic       en;
    logic [4:0] h;
    logic [5:0] m;
    logic       alarm;
    logic       motor;
    logic [1:0] act;
    logic [3:0] pend;
    logic [3:0] miss;
    logic       done;
  } vec_t;

  vec_t tab[$];

  function automatic vec_t vr(
    op_t op, int sl, int en, int h, int m,
    int al, int mo, int act, int pend,
    int miss, int dn);
    vec_t v;
    v.op    = op;
    v.sl    = 2'(sl);
    v.en    = 1'(en);
    v.h     = 5'(h);
    v.m     = 6'(m);
    v.alarm = 1'(al);
    v.motor = 1'(mo);
    v.act   = 2'(act);
    v.pend  = 4'(pend);
    v.miss  = 4'(miss);
    v.done  = 1'(dn);
    return v;
  endfunction

  task automatic chk(input string nm,
                     input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d",
               nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    bus.minute_tick = 1'b0;
    bus.cfg_we      = 1'b0;
    bus.ack         = 1'b0;
  endtask

  task automatic cfg(input int sl, input int en,
                     input int h, input int m);
    bus.cfg_we   = 1'b1;
    bus.cfg_slot = 2'(sl);
    bus.cfg_en   = 1'(en);
    bus.cfg_hour = 5'(h);
    bus.cfg_min  = 6'(m);
    step();
    quiet();
  endtask

  task automatic tick(input int h, input int m);
    bus.hours       = 5'(h);
    bus.minutes     = 6'(m);
    bus.minute_tick = 1'b1;
    step();
    quiet();
  endtask

  task automatic apply(input vec_t v);
    case (v.op)
      CFG: begin
        bus.cfg_we   = 1'b1;
        bus.cfg_slot = v.sl;
        bus.cfg_en   = v.en;
        bus.cfg_hour = v.h;
        bus.cfg_min  = v.m;
      end
      TCK: begin
        bus.hours       = v.h;
        bus.minutes     = v.m;
        bus.minute_tick = 1'b1;
      end
      ACK: bus.ack = 1'b1;
      default: ;
    endcase
    step();
    quiet();
  endtask

  task automatic chk_out(input string t,
    input int al, input int mo, input int act,
    input int pend, input int miss, input int dn);
    chk({t, " alarm"}, int'(bus.alarm), al);
    chk({t, " motor"}, int'(bus.motor_on), mo);
    chk({t, " active"}, int'(bus.active_slot), act);
    chk({t, " pending"}, int'(bus.pending), pend);
    chk({t, " missed"}, int'(bus.missed_count), miss);
    chk({t, " done"}, int'(bus.dose_done), dn);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int mcount;
    int exp_miss;

    bus.hours    = '0;
    bus.minutes  = '0;
    bus.cfg_slot = '0;
    bus.cfg_en   = 1'b0;
    bus.cfg_hour = '0;
    bus.cfg_min  = '0;
    quiet();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk_out("reset", 0, 0, 0, 0, 0, 0);

    // slot0 08:00: match, alert, ack, dispense, done
    tab.push_back(vr(CFG,0,1,8,0,   0,0,0,4'b0000,0,0));
    tab.push_back(vr(TCK,0,0,8,0,   0,0,0,4'b0001,0,0));
    tab.push_back(vr(NOP,0,0,0,0,   1,0,0,4'b0000,0,0));
    tab.push_back(vr(ACK,0,0,0,0,   0,1,0,4'b0000,0,0));
    for (int k = 0; k < DC - 1; k++)
      tab.push_back(vr(NOP,0,0,0,0, 0,1,0,4'b0000,0,0));
    tab.push_back(vr(NOP,0,0,0,0,   0,0,0,4'b0000,0,1));
    tab.push_back(vr(NOP,0,0,0,0,   0,0,0,4'b0000,0,0));
    // slot1 and slot3 at 12:30: slot1 first, then slot3
    tab.push_back(vr(CFG,1,1,12,30, 0,0,0,4'b0000,0,0));
    tab.push_back(vr(CFG,3,1,12,30, 0,0,0,4'b0000,0,0));
    tab.push_back(vr(TCK,0,0,12,30, 0,0,0,4'b1010,0,0));
    tab.push_back(vr(NOP,0,0,0,0,   1,0,1,4'b1000,0,0));
    tab.push_back(vr(ACK,0,0,0,0,   0,1,1,4'b1000,0,0));
    for (int k = 0; k < DC - 1; k++)
      tab.push_back(vr(NOP,0,0,0,0, 0,1,1,4'b1000,0,0));
    tab.push_back(vr(NOP,0,0,0,0,   0,0,1,4'b1000,0,1));
    tab.push_back(vr(NOP,0,0,0,0,   1,0,3,4'b0000,0,0));
    // slot3 times out after TO ticks; ack in IDLE ignored
    tab.push_back(vr(TCK,0,0,12,31, 1,0,3,4'b0000,0,0));
    tab.push_back(vr(TCK,0,0,12,32, 1,0,3,4'b0000,0,0));
    tab.push_back(vr(TCK,0,0,12,33, 0,0,3,4'b0000,1,0));
    tab.push_back(vr(ACK,0,0,0,0,   0,0,3,4'b0000,1,0));

    for (int i = 0; i < tab.size(); i++) begin
      apply(tab[i]);
      chk_out($sformatf("row%0d", i),
              int'(tab[i].alarm), int'(tab[i].motor),
              int'(tab[i].act), int'(tab[i].pend),
              int'(tab[i].miss), int'(tab[i].done));
    end

    // ack on the timeout tick wins; disable a pending slot
    cfg(2, 1, 10, 0);
    tick(10, 0);
    chk("race pending", int'(bus.pending), 4);
    step();
    chk("race alarm", int'(bus.alarm), 1);
    chk("race active", int'(bus.active_slot), 2);
    tick(10, 1);
    tick(10, 2);
    bus.ack = 1'b1;
    tick(10, 3);
    chk("race motor", int'(bus.motor_on), 1);
    chk("race alarm off", int'(bus.alarm), 0);
    chk("race missed", int'(bus.missed_count), 1);
    mcount = 1;
    tick(10, 0);
    chk("rematch pending", int'(bus.pending), 4);
    if (bus.motor_on) mcount++;
    cfg(2, 0, 10, 0);
    chk("disable pending", int'(bus.pending), 0);
    if (bus.motor_on) mcount++;
    for (int k = 0; k < 40 && bus.motor_on; k++) begin
      step();
      if (bus.motor_on) mcount++;
    end
    chk("dispense motor off", int'(bus.motor_on), 0);
    chk("dispense length", mcount, DC);
    chk("dispense done", int'(bus.dose_done), 1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("slot2 never served", int'(bus.alarm), 0);
    end

    // 16 more misses: counter saturates at 15
    for (int n = 1; n <= 16; n++) begin
      tick(8, 0);
      step();
      chk($sformatf("miss%0d alarm", n),
          int'(bus.alarm), 1);
      tick(9, 0);
      tick(9, 1);
      tick(9, 2);
      exp_miss = (1 + n > 15) ? 15 : 1 + n;
      chk($sformatf("miss%0d count", n),
          int'(bus.missed_count), exp_miss);
    end

    // reset during dispense
    tick(8, 0);
    step();
    bus.ack = 1'b1;
    step();
    quiet();
    chk("pre-reset motor", int'(bus.motor_on), 1);
    tick(12, 30);
    chk("pre-reset pending", int'(bus.pending), 10);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_out("mid reset", 0, 0, 0, 0, 0, 0);
    tick(8, 0);
    chk("post-reset pending", int'(bus.pending), 0);
    step();
    chk("post-reset alarm", int'(bus.alarm), 0);
    tick(12, 30);
    chk("post-reset pending2", int'(bus.pending), 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end
endmodule
